// File: rtl/burst_sweep_if.sv
// -----------------------------------------------------------------------------
// burst_sweep_if
//   Groups the signals between burst_sweep_ctrl and its surroundings: the
//   start/message handshake, the encoder and decoder taps, and the sweep
//   statistics.
//
//   Parameters: N (codeword bits), K (message bits), B (max burst length)
//
//   Signals (direction seen from the controller, i.e. the slave modport):
//     start          in   one-cycle sweep request
//     msg_in         in   message captured on an accepted start
//     msg_out        out  latched message, feeds the encoder
//     cw_in          in   encoder codeword
//     cw_err_out     out  corrupted codeword, feeds the decoder
//     dec_in         in   decoder output message
//     busy           out  sweep in progress
//     done           out  one-cycle end-of-sweep pulse
//     fail_cnt       out  failing vector count (saturating)
//     fail_any       out  sticky failure flag
//     first_fail_pos out  burst position of first failure
//     first_fail_pat out  burst pattern of first failure
//     vec_cnt        out  vectors completed
//
//   Modports: master (environment side), slave (controller side)
// -----------------------------------------------------------------------------
interface burst_sweep_if #(
  parameter int N = 29,
  parameter int K = 16,
  parameter int B = 6
);
  logic         start;
  logic [K-1:0] msg_in;
  logic [K-1:0] msg_out;
  logic [N-1:0] cw_in;
  logic [N-1:0] cw_err_out;
  logic [K-1:0] dec_in;
  logic         busy;
  logic         done;
  logic [15:0]  fail_cnt;
  logic         fail_any;
  logic [4:0]   first_fail_pos;
  logic [B-1:0] first_fail_pat;
  logic [15:0]  vec_cnt;

  modport master (
    output start, msg_in, cw_in, dec_in,
    input  msg_out, cw_err_out, busy, done, fail_cnt, fail_any,
           first_fail_pos, first_fail_pat, vec_cnt
  );

  modport slave (
    input  start, msg_in, cw_in, dec_in,
    output msg_out, cw_err_out, busy, done, fail_cnt, fail_any,
           first_fail_pos, first_fail_pat, vec_cnt
  );
endinterface

// File: rtl/burst_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// burst_sweep_ctrl
//   On-chip sequencer that exhaustively exercises a burst-error-correcting
//   encoder/decoder pair. It holds one message, walks every burst start
//   position (outer loop) and every B-bit pattern (inner loop), XORs each
//   pattern onto the encoder codeword before it reaches the decoder, and
//   counts decoded messages that differ from the original.
//
//   Ports:
//     clk  clock
//     rst  asynchronous reset, active-high
//     bus  burst_sweep_if.slave (start/msg_in/cw_in/dec_in in; msg_out,
//          cw_err_out, busy, done and statistics out)
//
//   Parameters: N, K, B, SETTLE (wait cycles between applying a vector and
//   sampling the decoder output).
//
//   Build option: BURST_SWEEP_STOP_ON_FAIL_EN -- when defined, the first
//   mismatch ends the sweep and the failing corrupted codeword is held on
//   cw_err_out until the next start.
// -----------------------------------------------------------------------------
module burst_sweep_ctrl #(
  parameter int N      = 29,
  parameter int K      = 16,
  parameter int B      = 6,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  burst_sweep_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int           WW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [4:0]   POS_LAST = 5'(N - B);
  localparam logic [B-1:0] PAT_LAST = '1;

`ifdef BURST_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t          state;
  logic [4:0]      pos;
  logic [B-1:0]    pat;
  logic [WW-1:0]   wait_cnt;
  logic            mismatch;
  logic            last_vec;

  // Pattern bit i lands on codeword bit pos+i; pos never exceeds N-B so the
  // shifted pattern always stays inside the codeword.
  function automatic logic [N-1:0] build_mask(input logic [4:0] p,
                                              input logic [B-1:0] t);
    logic [N-1:0] m;
    m = {{(N-B){1'b0}}, t};
    return m << p;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mismatch = (bus.dec_in != bus.msg_out);
  assign last_vec = (pat == PAT_LAST) && (pos == POS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      pos                <= '0;
      pat                <= '0;
      wait_cnt           <= '0;
      bus.msg_out        <= '0;
      bus.cw_err_out     <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.fail_cnt       <= '0;
      bus.fail_any       <= 1'b0;
      bus.first_fail_pos <= '0;
      bus.first_fail_pat <= '0;
      bus.vec_cnt        <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.msg_out        <= bus.msg_in;
            bus.fail_cnt       <= '0;
            bus.fail_any       <= 1'b0;
            bus.first_fail_pos <= '0;
            bus.first_fail_pat <= '0;
            bus.vec_cnt        <= '0;
            pos                <= '0;
            pat                <= '0;
            bus.busy           <= 1'b1;
            state              <= S_APPLY;
          end
        end

        // Apply: present the corrupted codeword to the decoder
        S_APPLY: begin
          bus.cw_err_out <= bus.cw_in ^ build_mask(pos, pat);
          wait_cnt       <= WW'(SETTLE);
          state          <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
        end

        // Settle: give the decoder time before its output is sampled
        S_SETTLE: begin
          wait_cnt <= wait_cnt - WW'(1);
          if (wait_cnt <= WW'(1)) state <= S_CHECK;
        end

        // Check: score the decoded message and step to the next vector
        S_CHECK: begin
          bus.vec_cnt <= bus.vec_cnt + 16'd1;
          if (mismatch) begin
            bus.fail_cnt <= sat_inc(bus.fail_cnt);
            bus.fail_any <= 1'b1;
            if (!bus.fail_any) begin
              bus.first_fail_pos <= pos;
              bus.first_fail_pat <= pat;
            end
          end
          if (STOP_ON_FAIL && mismatch) begin
            // Hold the failing corrupted codeword for probing.
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else if (last_vec) begin
            bus.cw_err_out <= bus.cw_in;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= S_DONE;
          end else begin
            if (pat == PAT_LAST) begin
              pat <= '0;
              pos <= pos + 5'd1;
            end else begin
              pat <= pat + B'(1);
            end
            state <= S_APPLY;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
